conv1d_param_loader: RTL and testbench

Sequencer that programs a conv1d parameter memory from a byte stream. It assembles bytes into weight vectors and bias words, then issues one write per memory entry on the conv1d configuration port. The order is bank 0..2 (weights) and then bank 3 (bias), with filters 0..NUM_FILTERS-1 inside each bank. It sits between the host/SPI byte interface and the conv1d configuration ports, and holds the conv datapath disabled while loading.

---
 rtl/conv1d_param_loader_if.sv | 37 +++
 rtl/conv1d_param_loader.sv | 167 ++++++++++++++++
 tb/tb_conv1d_param_loader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv1d_param_loader_if.sv
// Byte-stream and configuration-write bundle between the host/SPI side and the
// conv1d parameter loader.
interface conv1d_param_loader_if #(
  parameter int BW          = 8,
  parameter int COLUMN_LEN  = 13,
  parameter int NUM_FILTERS = 8
);
  localparam int VECTOR_BW = COLUMN_LEN * BW;
  localparam int ADDR_BW   = $clog2(NUM_FILTERS);
  localparam int BANK_BW   = 2;

  logic                 start_i;
  logic                 abort_i;
  logic [BW-1:0]        byte_i;
  logic                 byte_valid_i;
  logic                 byte_ready_o;
  logic                 wr_en_o;
  logic [BANK_BW-1:0]   rd_wr_bank_o;
  logic [ADDR_BW-1:0]   rd_wr_addr_o;
  logic [VECTOR_BW-1:0] wr_data_o;
  logic                 busy_o;
  logic                 done_o;

  // Host side: supplies the byte stream and control, observes the write port.
  modport master (
    output start_i, abort_i, byte_i, byte_valid_i,
    input  byte_ready_o, wr_en_o, rd_wr_bank_o, rd_wr_addr_o, wr_data_o,
           busy_o, done_o
  );

  // Loader side.
  modport slave (
    input  start_i, abort_i, byte_i, byte_valid_i,
    output byte_ready_o, wr_en_o, rd_wr_bank_o, rd_wr_addr_o, wr_data_o,
           busy_o, done_o
  );
endinterface

// File: rtl/conv1d_param_loader.sv
// Assembles a byte stream into conv1d weight vectors (banks 0-2) and bias words
// (bank 3) and issues one configuration write per memory entry.
module conv1d_param_loader #(
  parameter int BW          = 8,
  parameter int COLUMN_LEN  = 13,
  parameter int NUM_FILTERS = 8,
  parameter int BIAS_BW     = 32
) (
  input logic                  clk_i,
  input logic                  rst_n_i,
  conv1d_param_loader_if.slave bus
);
  localparam int VECTOR_BW   = COLUMN_LEN * BW;
  localparam int ADDR_BW     = $clog2(NUM_FILTERS);
  localparam int BANK_BW     = 2;
  localparam int BYTE_CNT_BW = $clog2(COLUMN_LEN);
  localparam int BIAS_BYTES  = BIAS_BW / BW;

  localparam logic [BANK_BW-1:0]     BIAS_BANK      = BANK_BW'(3);
  localparam logic [ADDR_BW-1:0]     LAST_ADDR      = ADDR_BW'(NUM_FILTERS - 1);
  localparam logic [BYTE_CNT_BW-1:0] LAST_WEIGHT_CNT = BYTE_CNT_BW'(COLUMN_LEN - 1);
  localparam logic [BYTE_CNT_BW-1:0] LAST_BIAS_CNT   = BYTE_CNT_BW'(BIAS_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [BANK_BW-1:0]     bank_q;
  logic [ADDR_BW-1:0]     addr_q;
  logic [BYTE_CNT_BW-1:0] byte_cnt_q;
  logic [VECTOR_BW-1:0]   assembly_q;
  logic [VECTOR_BW-1:0]   assembly_merged;
  logic [BANK_BW-1:0]     wr_bank_q;
  logic [ADDR_BW-1:0]     wr_addr_q;
  logic [VECTOR_BW-1:0]   wr_data_q;

  logic byte_ready;
  logic byte_accept;
  logic last_byte;
  logic last_entry;
  logic wr_en;
  logic busy;
  logic done;

  // Bias entries are shorter, so the end-of-entry byte count depends on the bank.
  assign last_byte   = (bank_q == BIAS_BANK) ? (byte_cnt_q == LAST_BIAS_CNT)
                                             : (byte_cnt_q == LAST_WEIGHT_CNT);
  assign last_entry  = (bank_q == BIAS_BANK) && (addr_q == LAST_ADDR);
  assign byte_accept = byte_ready & bus.byte_valid_i;

  always_comb begin
    assembly_merged = assembly_q;
    assembly_merged[int'(byte_cnt_q) * BW +: BW] = bus.byte_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort wins over a same-cycle byte, so byte_ready drops while abort_i is high.
  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        busy       = 1'b1;
        byte_ready = ~bus.abort_i;
        if (bus.abort_i) begin
          state_d = IDLE;
        end else if (byte_accept && last_byte) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        busy  = 1'b1;
        wr_en = 1'b1;
        if (bus.abort_i) begin
          state_d = IDLE;
        end else if (last_entry) begin
          state_d = DONE;
        end else begin
          state_d = COLLECT;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Write-port registers are loaded with the completed entry so they stay
  // stable through WRITE while the assembly register is recycled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bank_q     <= '0;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      assembly_q <= '0;
      wr_bank_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            bank_q     <= '0;
            addr_q     <= '0;
            byte_cnt_q <= '0;
            assembly_q <= '0;
          end
        end
        COLLECT: begin
          if (byte_accept) begin
            assembly_q <= assembly_merged;
            byte_cnt_q <= byte_cnt_q + BYTE_CNT_BW'(1);
            if (last_byte) begin
              wr_data_q <= assembly_merged;
              wr_bank_q <= bank_q;
              wr_addr_q <= addr_q;
            end
          end
        end
        WRITE: begin
          byte_cnt_q <= '0;
          assembly_q <= '0;
          if (addr_q == LAST_ADDR) begin
            addr_q <= '0;
            bank_q <= bank_q + BANK_BW'(1);
          end else begin
            addr_q <= addr_q + ADDR_BW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.byte_ready_o = byte_ready;
  assign bus.wr_en_o      = wr_en;
  assign bus.rd_wr_bank_o = wr_bank_q;
  assign bus.rd_wr_addr_o = wr_addr_q;
  assign bus.wr_data_o    = wr_data_q;
  assign bus.busy_o       = busy;
  assign bus.done_o       = done;

endmodule

// File: tb/tb_conv1d_param_loader.sv
// Directed bench for conv1d_param_loader: reset, idle, full loads (continuous,
// throttled), abort and mid-load async reset.
module tb_conv1d_param_loader;
  localparam int BW           = 8;
  localparam int COLUMN_LEN   = 13;
  localparam int NUM_FILTERS  = 8;
  localparam int BIAS_BW      = 32;
  localparam int VECTOR_BW    = COLUMN_LEN * BW;
  localparam int BIAS_BYTES   = BIAS_BW / BW;
  localparam int W_ENTRIES    = 3 * NUM_FILTERS;
  localparam int W_BYTES      = W_ENTRIES * COLUMN_LEN;
  localparam int TOTAL_WRITES = 4 * NUM_FILTERS;
  localparam int TOTAL_BYTES  = W_BYTES + NUM_FILTERS * BIAS_BYTES;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  conv1d_param_loader_if #(.BW(BW), .COLUMN_LEN(COLUMN_LEN), .NUM_FILTERS(NUM_FILTERS)) bus ();

  conv1d_param_loader #(
    .BW(BW), .COLUMN_LEN(COLUMN_LEN), .NUM_FILTERS(NUM_FILTERS), .BIAS_BW(BIAS_BW)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected wr_data for write n when byte k of the stream is k mod 256.
  function automatic logic [VECTOR_BW-1:0] exp_data(input int n);
    logic [VECTOR_BW-1:0] d;
    int base;
    int cnt;
    d = '0;
    if (n < W_ENTRIES) begin
      base = n * COLUMN_LEN;
      cnt  = COLUMN_LEN;
    end else begin
      base = W_BYTES + (n - W_ENTRIES) * BIAS_BYTES;
      cnt  = BIAS_BYTES;
    end
    for (int j = 0; j < cnt; j++) d[j*BW +: BW] = 8'((base + j) % 256);
    return d;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks += 7;
    if (bus.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %0h want 0", bus.busy_o); end
    if (bus.byte_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready got %0h want 0", bus.byte_ready_o); end
    if (bus.wr_en_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wr_en got %0h want 0", bus.wr_en_o); end
    if (bus.done_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %0h want 0", bus.done_o); end
    if (bus.rd_wr_bank_o !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_bank got %0h want 0", bus.rd_wr_bank_o); end
    if (bus.rd_wr_addr_o !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_addr got %0h want 0", bus.rd_wr_addr_o); end
    if (bus.wr_data_o !== '0) begin n_fail++; $display("[TB] FAIL reset_data got %0h want 0", bus.wr_data_o); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_busy got %0h want 0", bus.busy_o); end
  endtask

  task automatic test_idle_ignores_bytes;
    bus.byte_valid_i = 1'b1;
    bus.byte_i       = 8'hAA;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks += 3;
      if (bus.byte_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_ready cyc %0d got %0h want 0", i, bus.byte_ready_o); end
      if (bus.wr_en_o !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_wr_en cyc %0d got %0h want 0", i, bus.wr_en_o); end
      if (bus.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_busy cyc %0d got %0h want 0", i, bus.busy_o); end
    end
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic test_full_load(input bit throttle, input bit poke_start, input string tag);
    int cyc, k, nwr, last_acc, last_wr, done_cnt, done_cyc, exp_bytes;
    logic [VECTOR_BW-1:0] exp;
    cyc = 0; k = 0; nwr = 0; last_acc = -100; last_wr = -100; done_cnt = 0; done_cyc = -1;
    @(negedge clk);
    bus.start_i = 1'b1; bus.abort_i = 1'b0; bus.byte_valid_i = 1'b0;
    while (done_cnt == 0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      bus.start_i = poke_start && (cyc == 50);
      if (bus.wr_en_o === 1'b1) begin
        exp       = exp_data(nwr);
        exp_bytes = (nwr < W_ENTRIES) ? (nwr + 1) * COLUMN_LEN
                                      : W_BYTES + (nwr - W_ENTRIES + 1) * BIAS_BYTES;
        n_checks += 7;
        if (int'(bus.rd_wr_bank_o) !== nwr / NUM_FILTERS) begin n_fail++; $display("[TB] FAIL %s wr%0d_bank got %0d want %0d", tag, nwr, bus.rd_wr_bank_o, nwr / NUM_FILTERS); end
        if (int'(bus.rd_wr_addr_o) !== nwr % NUM_FILTERS) begin n_fail++; $display("[TB] FAIL %s wr%0d_addr got %0d want %0d", tag, nwr, bus.rd_wr_addr_o, nwr % NUM_FILTERS); end
        if (bus.wr_data_o !== exp) begin n_fail++; $display("[TB] FAIL %s wr%0d_data got %0h want %0h", tag, nwr, bus.wr_data_o, exp); end
        if (k !== exp_bytes) begin n_fail++; $display("[TB] FAIL %s wr%0d_bytes_consumed got %0d want %0d", tag, nwr, k, exp_bytes); end
        if (cyc !== last_acc + 1) begin n_fail++; $display("[TB] FAIL %s wr%0d_latency got cyc %0d want %0d", tag, nwr, cyc, last_acc + 1); end
        if (bus.busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL %s wr%0d_busy got %0h want 1", tag, nwr, bus.busy_o); end
        if (bus.byte_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL %s wr%0d_ready got %0h want 0", tag, nwr, bus.byte_ready_o); end
        if (nwr == 0) begin
          n_checks++;
          if (bus.wr_data_o !== 104'h0C0B0A09080706050403020100) begin n_fail++; $display("[TB] FAIL %s first_write_data got %0h want 0c0b0a09080706050403020100", tag, bus.wr_data_o); end
        end
        if (nwr == 8) begin
          n_checks++;
          if (bus.rd_wr_bank_o !== 2'd1 || bus.rd_wr_addr_o !== 3'd0) begin n_fail++; $display("[TB] FAIL %s wrap9 got bank %0d addr %0d want bank 1 addr 0", tag, bus.rd_wr_bank_o, bus.rd_wr_addr_o); end
        end
        if (nwr == 24) begin
          n_checks += 2;
          if (bus.wr_data_o[31:0] !== 32'h3B3A3938) begin n_fail++; $display("[TB] FAIL %s bias0_low got %0h want 3b3a3938", tag, bus.wr_data_o[31:0]); end
          if (bus.wr_data_o[VECTOR_BW-1:32] !== '0) begin n_fail++; $display("[TB] FAIL %s bias0_upper got %0h want 0", tag, bus.wr_data_o[VECTOR_BW-1:32]); end
        end
        nwr++;
        last_wr = cyc;
      end
      if (bus.done_o === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        n_checks++;
        if (bus.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL %s done_busy got %0h want 0", tag, bus.busy_o); end
      end else begin
        bus.byte_valid_i = throttle ? logic'(cyc % 2 == 1) : 1'b1;
        bus.byte_i       = 8'(k);
        #1;
        if (bus.byte_valid_i === 1'b1 && bus.byte_ready_o === 1'b1) begin
          last_acc = cyc;
          k++;
        end
      end
    end
    bus.byte_valid_i = 1'b0;
    bus.start_i      = 1'b0;
    n_checks += 4;
    if (done_cnt == 0) begin n_fail++; $display("[TB] FAIL %s done_timeout got no done after %0d cycles want done", tag, cyc); end
    if (nwr !== TOTAL_WRITES) begin n_fail++; $display("[TB] FAIL %s write_count got %0d want %0d", tag, nwr, TOTAL_WRITES); end
    if (k !== TOTAL_BYTES) begin n_fail++; $display("[TB] FAIL %s byte_count got %0d want %0d", tag, k, TOTAL_BYTES); end
    if (done_cyc !== last_wr + 1) begin n_fail++; $display("[TB] FAIL %s done_latency got cyc %0d want %0d", tag, done_cyc, last_wr + 1); end
    if (!throttle) begin
      n_checks++;
      if (done_cyc !== TOTAL_BYTES + TOTAL_WRITES + 1) begin n_fail++; $display("[TB] FAIL %s load_time got %0d want %0d", tag, done_cyc, TOTAL_BYTES + TOTAL_WRITES + 1); end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks += 2;
      if (bus.done_o !== 1'b0) begin n_fail++; $display("[TB] FAIL %s done_single_pulse got %0h want 0", tag, bus.done_o); end
      if (bus.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL %s idle_after_done_busy got %0h want 0", tag, bus.busy_o); end
    end
  endtask

  task automatic test_abort;
    int cyc, k, nwr;
    bit aborted;
    @(negedge clk);
    bus.start_i = 1'b1; bus.abort_i = 1'b1; bus.byte_valid_i = 1'b0;
    @(negedge clk);
    bus.start_i = 1'b0; bus.abort_i = 1'b0;
    n_checks++;
    if (bus.busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL start_beats_abort_busy got %0h want 1", bus.busy_o); end
    cyc = 0; k = 0; nwr = 0; aborted = 1'b0;
    while (!aborted && cyc < 200) begin
      if (bus.wr_en_o === 1'b1) begin
        n_checks += 2;
        if (bus.rd_wr_bank_o !== 2'd0) begin n_fail++; $display("[TB] FAIL abort_wr_bank got %0d want 0", bus.rd_wr_bank_o); end
        if (bus.rd_wr_addr_o !== 3'd0) begin n_fail++; $display("[TB] FAIL abort_wr_addr got %0d want 0", bus.rd_wr_addr_o); end
        nwr++;
      end
      bus.byte_valid_i = 1'b1;
      bus.byte_i       = 8'(k);
      if (k == 20) begin
        bus.abort_i = 1'b1;
        #1;
        n_checks++;
        if (bus.byte_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_ready_forced got %0h want 0", bus.byte_ready_o); end
        aborted = 1'b1;
      end else begin
        #1;
        if (bus.byte_ready_o === 1'b1) k++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.abort_i = 1'b0;
    n_checks++;
    if (!aborted) begin n_fail++; $display("[TB] FAIL abort_timeout got %0d bytes want 20", k); end
    for (int i = 0; i < 10; i++) begin
      n_checks += 4;
      if (bus.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_busy cyc %0d got %0h want 0", i, bus.busy_o); end
      if (bus.byte_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_ready cyc %0d got %0h want 0", i, bus.byte_ready_o); end
      if (bus.done_o !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_done cyc %0d got %0h want 0", i, bus.done_o); end
      if (bus.wr_en_o === 1'b1) nwr++;
      if (bus.wr_en_o !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_wr_en cyc %0d got %0h want 0", i, bus.wr_en_o); end
      @(negedge clk);
    end
    bus.byte_valid_i = 1'b0;
    n_checks++;
    if (nwr !== 1) begin n_fail++; $display("[TB] FAIL abort_write_count got %0d want 1", nwr); end
  endtask

  task automatic test_reset_mid_collect;
    @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i      = 1'b0;
    bus.byte_valid_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      bus.byte_i = 8'(i + 1);
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks += 7;
    if (bus.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy got %0h want 0", bus.busy_o); end
    if (bus.byte_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_ready got %0h want 0", bus.byte_ready_o); end
    if (bus.wr_en_o !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_wr_en got %0h want 0", bus.wr_en_o); end
    if (bus.done_o !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_done got %0h want 0", bus.done_o); end
    if (bus.rd_wr_bank_o !== 2'd0) begin n_fail++; $display("[TB] FAIL midrst_bank got %0h want 0", bus.rd_wr_bank_o); end
    if (bus.rd_wr_addr_o !== 3'd0) begin n_fail++; $display("[TB] FAIL midrst_addr got %0h want 0", bus.rd_wr_addr_o); end
    if (bus.wr_data_o !== '0) begin n_fail++; $display("[TB] FAIL midrst_data got %0h want 0", bus.wr_data_o); end
    bus.byte_valid_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.done_o !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_no_done got %0h want 0", bus.done_o); end
    #2;
    rst_n = 1'b1;
    test_full_load(1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    rst_n            = 1'b0;
    bus.start_i      = 1'b0;
    bus.abort_i      = 1'b0;
    bus.byte_i       = '0;
    bus.byte_valid_i = 1'b0;
    $display("[TB] starting conv1d_param_loader bench");
    test_reset;
    test_idle_ignores_bytes;
    test_full_load(1'b0, 1'b0, "continuous");
    test_full_load(1'b1, 1'b1, "throttled");
    test_abort;
    test_full_load(1'b0, 1'b0, "restart");
    test_reset_mid_collect;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
